// File: rtl/fsk_pkg.sv
// rtl/fsk_pkg.sv - FSK framing states and frame constants shared by the receive and transmit framers
package fsk_pkg;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        PARITY,
        COMPLETE
    } fsk_state_e;

    localparam int                    DEF_DATA_W       = 12;
    localparam int                    DEF_SYNC_W       = 8;
    localparam logic [DEF_SYNC_W-1:0] DEF_SYNC_PATTERN = 8'hA5;

endpackage

// File: rtl/fsk_sync_detect.sv
// rtl/fsk_sync_detect.sv - sync word shift register with match on the post-shift value
module fsk_sync_detect
    import fsk_pkg::*;
#(
    parameter int                SYNC_W  = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] PATTERN = DEF_SYNC_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    input  logic clear,
    output logic match
);

    logic [SYNC_W-1:0] sr;
    logic [SYNC_W-1:0] sr_next;

    assign sr_next = {sr[SYNC_W-2:0], din};
    // Match looks at the value the register is about to hold, so the frame
    // starts on the same edge that shifts in the last sync bit.
    assign match   = tick && !clear && (sr_next == PATTERN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (tick) begin
            sr <= sr_next;
        end
    end

endmodule

// File: rtl/fsk_frame_rx.sv
// rtl/fsk_frame_rx.sv - FSK receive framer: sync hunt, codeword capture, valid/ready output; option FSK_RX_PARITY_EN
module fsk_frame_rx
    import fsk_pkg::*;
#(
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                SYNC_W       = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
    parameter int                ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_tick,
    input  logic                 din,
    output logic [DATA_W-1:0]    word,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 overrun,
    output logic                 in_frame,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    fsk_state_e        state;
    logic [DATA_W-1:0] payload;
    logic [CNT_W-1:0]  bit_cnt;
    logic              sync_tick;
    logic              sync_clear;
    logic              sync_match;
    logic              parity_bad;

    assign sync_tick = bit_tick && (state == HUNT);

`ifdef FSK_RX_PARITY_EN
    assign parity_bad = (state == PARITY) && bit_tick && (din != ^payload);
`else
    assign parity_bad = 1'b0;
    assign err_count  = '0;
`endif

    // Wiping the sync register at frame end stops payload tail bits from
    // combining with the next sync into a false match.
    assign sync_clear = (state == COMPLETE) || parity_bad;

    fsk_sync_detect #(
        .SYNC_W  (SYNC_W),
        .PATTERN (SYNC_PATTERN)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .tick  (sync_tick),
        .din   (din),
        .clear (sync_clear),
        .match (sync_match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            payload    <= '0;
            bit_cnt    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
            in_frame   <= 1'b0;
`ifdef FSK_RX_PARITY_EN
            err_count  <= '0;
`endif
        end else begin
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            case (state)
                HUNT: begin
                    if (sync_match) begin
                        bit_cnt  <= '0;
                        state    <= PAYLOAD;
                        in_frame <= 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (bit_tick) begin
                        payload <= {payload[DATA_W-2:0], din};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
`ifdef FSK_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= COMPLETE;
`endif
                        end
                    end
                end
`ifdef FSK_RX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        if (parity_bad) begin
                            state    <= HUNT;
                            in_frame <= 1'b0;
                            if (err_count != '1) begin
                                err_count <= err_count + ERR_CNT_W'(1);
                            end
                        end else begin
                            state <= COMPLETE;
                        end
                    end
                end
`endif
                COMPLETE: begin
                    // A completion overrides a same-cycle handshake clear.
                    word       <= payload;
                    word_valid <= 1'b1;
                    if (word_valid && !word_ready) begin
                        overrun <= 1'b1;
                    end
                    state    <= HUNT;
                    in_frame <= 1'b0;
                end
                default: begin
                    state    <= HUNT;
                    in_frame <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fsk_frame_rx.md
Name: fsk_frame_rx

Overview:
- Receive-side framer directly downstream of the FSK demodulator.
- Takes the demodulated serial bit stream, hunts for a fixed sync pattern and shifts in one DATA_W-bit Hamming codeword, MSB first.
- Presents the codeword with a valid/ready handshake to the Hamming decoder.
- Replaces the ad-hoc edge-latched capture with a single-clock, strobe-driven design.

Parameters:
- DATA_W, 12, payload width in bits (Hamming codeword).
- SYNC_W, 8, sync pattern length in bits.
- SYNC_PATTERN, 8'hA5, sync word, transmitted MSB first.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- bit_tick  in  1  one-clk strobe at the centre of each bit period
- din  in  1  demodulated serial bit, sampled only when bit_tick=1
- word  out  DATA_W  last received codeword
- word_valid  out  1  word holds an unconsumed codeword
- word_ready  in  1  consumer accepts word when word_valid&&word_ready
- overrun  out  1  sticky: a frame completed while word_valid was still 1
- in_frame  out  1  high while in PAYLOAD or PARITY state
- err_count  out  ERR_CNT_W  saturating count of errored frames

Behaviour:
- Reset (rst=0, async): state=HUNT, sync shift register=0, bit counter=0, word=0, word_valid=0, overrun=0, in_frame=0, err_count=0. Reset mid-frame discards the partial frame.
- All state changes occur on posedge clk. din is ignored when bit_tick=0.
- HUNT:
  - On each bit_tick, shift din into the SYNC_W-bit register (LSB in).
  - If the post-shift value equals SYNC_PATTERN: clear the bit counter, go to PAYLOAD on the next clk.
  - in_frame rises in the same cycle as the state change.
- PAYLOAD:
  - On each bit_tick, shift din into the payload register (LSB in, so the first bit ends up at the MSB) and increment the counter.
  - On the DATA_W-th bit: go to PARITY (macro defined) or COMPLETE (macro undefined).
- PARITY: see Optional Feature.
- COMPLETE, one clk:
  - word <= payload register.
  - If word_valid is 1 and not being consumed this cycle, set overrun=1.
  - word_valid <= 1.
  - Clear the sync register, go to HUNT, in_frame <= 0.
  - Clearing the sync register guarantees the payload tail cannot match the next sync.
- Latency: word_valid rises 2 clk after the bit_tick that samples the last frame bit.
- Handshake:
  - word_valid falls on the clk after word_valid&&word_ready.
  - word is stable while word_valid=1, except on overrun.
  - If a completion and a handshake coincide, the new word wins: word_valid stays 1 and overrun is not set.
- overrun is cleared only by reset.
- err_count saturates at 2^ERR_CNT_W-1 and does not wrap.
- A bit_tick arriving during COMPLETE is lost; the transmitter guarantees at least 2 clk between ticks.

Optional Feature:
- Macro: FSK_RX_PARITY_EN.
- Defined:
  - Frame = SYNC + DATA_W payload + 1 even-parity bit.
  - In PARITY, on bit_tick compare din with XOR of the payload.
  - Match: go to COMPLETE.
  - Mismatch: increment err_count, discard the frame (word and word_valid unchanged), clear the sync register, return to HUNT.
- Undefined:
  - No parity bit; PARITY state is absent.
  - err_count is tied to 0.

Decomposition:
- Shared package fsk_pkg:
  - state enum (HUNT, PAYLOAD, PARITY, COMPLETE);
  - default SYNC_PATTERN and DATA_W constants, which the transmit-side framer also uses.
- One sub-module, fsk_sync_detect: SYNC_W shift register plus comparator, with inputs tick, din and clear, and output match.

Test Plan:
- Reset, idle ticks with din=0 for 40 bits -> word_valid=0, in_frame=0, err_count=0.
- Sync 8'hA5 then payload 12'hB3C (parity 1 when enabled), word_ready=1 -> word=12'hB3C, one-clk word_valid pulse, overrun=0.
- Pattern 8'hA4 followed by 12'hFFF -> no frame detected, word_valid stays 0.
- Two back-to-back frames 12'h123 then 12'h456 with word_ready=0 -> word=12'h456, word_valid=1, overrun=1.
- FSK_RX_PARITY_EN only: frame 12'h001 with parity bit 0 -> err_count=1, word unchanged, next correct frame accepted.
- Assert rst=0 after 5 payload bits, release, send full frame 12'hABC -> only 12'hABC delivered, no stale bits.
